i2c_config_seq: RTL and testbench

- Table-driven sequencer that owns the byte-level I2C master's request interface.
- After reset (or on `start`), walks a synchronous configuration LUT of {dev_addr, reg_addr, data} entries and issues one I2C write per entry.
- Optional read-back verify, bounded retry on NACK/mismatch, and inline delay entries.
- Sits between the HDMI transmitter init LUT and the I2C master; reports done/fail to board logic.

---
 rtl/i2c_cfg_pkg.sv | 9 +
 rtl/i2c_cfg_timer.sv | 18 +
 rtl/i2c_config_seq.sv | 142 ++++++++++++++
 tb/tb_i2c_config_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared state encoding and LUT entry layout for the I2C configuration sequencer
package i2c_cfg_pkg;
    typedef enum logic [3:0] {PWRUP, FETCH, LATCH, WR, RD, ERR, GAP, DELAY, NEXT, DONE, FAIL} cfg_state_t;
    localparam logic [7:0] DELAY_DEV = 8'hFF;
    localparam int DEV_LSB = 16;
    localparam int REG_LSB = 8;
    localparam int DAT_LSB = 0;
    localparam int VFY_GAP = 1;
endpackage

// File: rtl/i2c_cfg_timer.sv
// i2c_cfg_timer: loadable down-counter with zero flag, shared by power-up, retry-gap and delay waits
module i2c_cfg_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/i2c_config_seq.sv
// i2c_config_seq: walks a configuration LUT and issues one I2C write (optionally verified) per entry
module i2c_config_seq
    import i2c_cfg_pkg::*;
#(
    parameter int LUT_AW       = 8,
    parameter int PWRUP_CYCLES = 1000000,
    parameter int RETRY_MAX    = 3,
    parameter int RETRY_GAP    = 1000,
    parameter int DELAY_UNIT   = 1000,
    parameter int VERIFY       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LUT_AW-1:0] lut_size,
    output logic [LUT_AW-1:0] lut_index,
    input  logic [23:0]       lut_data,
    output logic              i2c_write_req,
    input  logic              i2c_write_req_ack,
    output logic              i2c_read_req,
    input  logic              i2c_read_req_ack,
    output logic [7:0]        i2c_slave_dev_addr,
    output logic [7:0]        i2c_slave_reg_addr,
    output logic [7:0]        i2c_write_data,
    input  logic [7:0]        i2c_read_data,
    input  logic              i2c_error,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [LUT_AW-1:0] fail_index
);
    localparam longint MAX_A = (PWRUP_CYCLES > RETRY_GAP) ? longint'(PWRUP_CYCLES) : longint'(RETRY_GAP);
    localparam longint MAX_B = 64'd65535 * longint'(DELAY_UNIT);
    localparam int TW = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

    cfg_state_t r_state, w_next;
    logic [LUT_AW-1:0] r_idx, r_fail_idx, w_idx_inc;
    logic [RW-1:0] r_retry, w_retry_inc;
    logic [7:0] r_dev, r_reg, r_data;
    logic r_pwr_arm, r_rd_next, w_restart, w_tmr_load, w_tmr_zero;
    logic [TW-1:0] w_tmr_val;

    assign w_idx_inc = r_idx + LUT_AW'(1);
    assign w_retry_inc = r_retry + RW'(1);
    assign w_restart = ((r_state == DONE) || (r_state == FAIL)) && start;

    i2c_cfg_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PWRUP;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val = '0;
        case (r_state)
            // First power-up cycle arms the timer; it resets to zero like every other counter
            PWRUP: if (!r_pwr_arm) begin
                w_tmr_load = 1'b1;
                w_tmr_val = TW'(PWRUP_CYCLES);
            end else if (w_tmr_zero) w_next = (lut_size == '0) ? DONE : FETCH;
            FETCH: w_next = LATCH;
            LATCH: if (lut_data[DEV_LSB +: 8] != DELAY_DEV) w_next = WR;
            else if (lut_data[15:0] == 16'd0) w_next = NEXT;
            else begin
                w_next = DELAY;
                w_tmr_load = 1'b1;
                w_tmr_val = TW'(lut_data[15:0]) * TW'(DELAY_UNIT);
            end
            // Verify reads go through a short GAP so the master sees an idle spell between requests
            WR: if (i2c_write_req_ack) begin
                if (i2c_error) w_next = ERR;
                else if (VERIFY != 0) begin
                    w_next = GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val = TW'(VFY_GAP);
                end else w_next = NEXT;
            end
            RD: if (i2c_read_req_ack) w_next = (i2c_error || (i2c_read_data != r_data)) ? ERR : NEXT;
            ERR: if (w_retry_inc < RMAX) begin
                w_next = GAP;
                w_tmr_load = 1'b1;
                w_tmr_val = TW'(RETRY_GAP);
            end else w_next = FAIL;
            GAP: if (w_tmr_zero) w_next = r_rd_next ? RD : WR;
            DELAY: if (w_tmr_zero) w_next = NEXT;
            NEXT: w_next = (w_idx_inc == lut_size) ? DONE : FETCH;
            DONE, FAIL: if (start) w_next = (lut_size == '0) ? DONE : FETCH;
            default: w_next = PWRUP;
        endcase
    end

    always_comb begin
        i2c_write_req = (r_state == WR);
        i2c_read_req = (r_state == RD);
        done = (r_state == DONE);
        fail = (r_state == FAIL);
        busy = (r_state != DONE) && (r_state != FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_arm <= 1'b0;
            r_rd_next <= 1'b0;
            r_idx <= '0;
            r_retry <= '0;
            r_fail_idx <= '0;
            {r_dev, r_reg, r_data} <= '0;
        end else begin
            r_pwr_arm <= 1'b1;
            r_rd_next <= (r_state == WR) ? (w_next == GAP) : ((r_state == GAP) && r_rd_next);
            if (r_state == LATCH) {r_dev, r_reg, r_data} <= lut_data;
            if (r_state == ERR) r_retry <= w_retry_inc;
            if ((r_state == ERR) && (w_next == FAIL)) r_fail_idx <= r_idx;
            if (r_state == NEXT) begin
                r_idx <= w_idx_inc;
                r_retry <= '0;
            end
            if (w_restart) begin
                r_idx <= '0;
                r_retry <= '0;
                r_fail_idx <= '0;
            end
        end
    end

    assign lut_index = r_idx;
    assign fail_index = r_fail_idx;
    assign i2c_slave_dev_addr = r_dev;
    assign i2c_slave_reg_addr = r_reg;
    assign i2c_write_data = r_data;
endmodule

// File: tb/tb_i2c_config_seq.sv
// tb_i2c_config_seq: directed bench with two sequencers (write-only and verify) and a shared I2C slave model
module tb_i2c_config_seq;
    localparam int AW = 4;

    typedef struct {
        logic [23:0] entry;
        int wr_retry;
        int wr_vfy;
        int rd_vfy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start [2];
    logic [AW-1:0] lut_size [2], lut_index [2], fidx [2];
    logic [23:0] lut_data [2];
    logic wreq [2], rreq [2], wack [2], rack [2], ierr [2], busy [2], done [2], fail [2];
    logic [7:0] dev [2], sreg [2], wdat [2], rdat [2];
    logic [23:0] lut [2][16];

    i2c_config_seq #(.LUT_AW(AW), .PWRUP_CYCLES(100), .RETRY_MAX(3), .RETRY_GAP(50), .DELAY_UNIT(10), .VERIFY(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .lut_size(lut_size[0]), .lut_index(lut_index[0]),
        .lut_data(lut_data[0]), .i2c_write_req(wreq[0]), .i2c_write_req_ack(wack[0]), .i2c_read_req(rreq[0]),
        .i2c_read_req_ack(rack[0]), .i2c_slave_dev_addr(dev[0]), .i2c_slave_reg_addr(sreg[0]),
        .i2c_write_data(wdat[0]), .i2c_read_data(rdat[0]), .i2c_error(ierr[0]), .busy(busy[0]),
        .done(done[0]), .fail(fail[0]), .fail_index(fidx[0])
    );

    i2c_config_seq #(.LUT_AW(AW), .PWRUP_CYCLES(100), .RETRY_MAX(3), .RETRY_GAP(50), .DELAY_UNIT(10), .VERIFY(1)) u_vfy (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .lut_size(lut_size[1]), .lut_index(lut_index[1]),
        .lut_data(lut_data[1]), .i2c_write_req(wreq[1]), .i2c_write_req_ack(wack[1]), .i2c_read_req(rreq[1]),
        .i2c_read_req_ack(rack[1]), .i2c_slave_dev_addr(dev[1]), .i2c_slave_reg_addr(sreg[1]),
        .i2c_write_data(wdat[1]), .i2c_read_data(rdat[1]), .i2c_error(ierr[1]), .busy(busy[1]),
        .done(done[1]), .fail(fail[1]), .fail_index(fidx[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int lat [2], att [2][256], ratt [2][256], gap_before [2][256];
    logic [7:0] mem [2][256], devm [2][256];
    int wr_n [2], rd_n [2], overlap [2], stab [2], gapv [2], seqe [2];
    int first_req [2], last_fall [2], min_rgap [2];
    logic [7:0] first_reg [2], last_wr [2], cap_dev [2], cap_reg [2], cap_dat [2];
    logic pw [2], nacked [2];
    logic [7:0] nack_reg [2], bad_reg [2];
    int nack_n [2], bad_n [2];
    logic hold [2];

    // Slave model: ROM read, 3-cycle ack latency, programmable NACKs and bad readbacks, protocol monitors
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            lut_data[g] = lut[g][lut_index[g]];
            wack[g] = 1'b0;
            rack[g] = 1'b0;
            ierr[g] = 1'b0;
            if (!rst_n || start[g]) begin
                for (int r = 0; r < 256; r++) begin
                    att[g][r] = 0;
                    ratt[g][r] = 0;
                    gap_before[g][r] = 0;
                    mem[g][r] = 8'h00;
                    devm[g][r] = 8'h00;
                end
                wr_n[g] = 0; rd_n[g] = 0; overlap[g] = 0; stab[g] = 0; gapv[g] = 0; seqe[g] = 0;
                first_req[g] = -1; last_fall[g] = -1000; min_rgap[g] = 1000000;
                lat[g] = 0; nacked[g] = 1'b0; last_wr[g] = 8'h00; first_reg[g] = 8'h00;
            end else if (wreq[g] || rreq[g]) begin
                if (wreq[g] && rreq[g]) overlap[g]++;
                if (!pw[g]) begin
                    if (cyc - last_fall[g] < 2) gapv[g]++;
                    gap_before[g][sreg[g]] = cyc - last_fall[g];
                    if (nacked[g] && (cyc - last_fall[g] < min_rgap[g])) min_rgap[g] = cyc - last_fall[g];
                    nacked[g] = 1'b0;
                    if (first_req[g] < 0) begin
                        first_req[g] = cyc;
                        first_reg[g] = sreg[g];
                    end
                    cap_dev[g] = dev[g]; cap_reg[g] = sreg[g]; cap_dat[g] = wdat[g];
                    lat[g] = 0;
                end else if ({dev[g], sreg[g], wdat[g]} != {cap_dev[g], cap_reg[g], cap_dat[g]}) stab[g]++;
                lat[g]++;
                if (lat[g] == 3 && !hold[g]) begin
                    if (wreq[g]) begin
                        ierr[g] = (sreg[g] == nack_reg[g]) && (att[g][sreg[g]] < nack_n[g]);
                        att[g][sreg[g]]++;
                        wr_n[g]++;
                        devm[g][sreg[g]] = dev[g];
                        last_wr[g] = sreg[g];
                        if (ierr[g]) nacked[g] = 1'b1;
                        else mem[g][sreg[g]] = wdat[g];
                        wack[g] = 1'b1;
                    end else begin
                        rdat[g] = ((sreg[g] == bad_reg[g]) && (ratt[g][sreg[g]] < bad_n[g])) ?
                                  mem[g][sreg[g]] - 8'd1 : mem[g][sreg[g]];
                        ratt[g][sreg[g]]++;
                        rd_n[g]++;
                        if (last_wr[g] != sreg[g]) seqe[g]++;
                        rack[g] = 1'b1;
                    end
                end
            end else if (pw[g]) last_fall[g] = cyc;
            pw[g] = rst_n && (wreq[g] || rreq[g]);
        end
    end

    int nchk = 0, nerr = 0;
    int rel_cyc, start_cyc;
    vec_t tbl [3];

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        nchk++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(input int g, input string nm);
        int n = 0;
        while (!done[g] && !fail[g] && n < 3000) begin
            tick();
            n++;
        end
        chk({nm, " finished"}, longint'(done[g] || fail[g]), 1);
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    initial begin
        tbl[0] = '{24'h720835, 1, 2, 2};
        tbl[1] = '{24'h724110, 3, 1, 1};
        tbl[2] = '{24'h7AD6C0, 1, 1, 1};
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; lut_size[g] = '0; hold[g] = 1'b0;
            nack_n[g] = 0; bad_n[g] = 0; nack_reg[g] = 8'h00; bad_reg[g] = 8'h00;
            for (int i = 0; i < 16; i++) lut[g][i] = 24'h0;
            for (int i = 0; i < 3; i++) lut[g][i] = tbl[i].entry;
        end

        // basic run, start ignored during power-up; second sequencer has an empty LUT
        lut_size[0] = 3;
        rst_n = 1'b0;
        tick(3);
        chk("reset write_req", wreq[0], 0);
        chk("reset read_req", rreq[0], 0);
        chk("reset done", done[0], 0);
        chk("reset fail", fail[0], 0);
        chk("reset lut_index", lut_index[0], 0);
        chk("reset fail_index", fidx[0], 0);
        chk("reset dev_addr", dev[0], 0);
        rst_n = 1'b1;
        rel_cyc = cyc;
        tick(20);
        pulse_start(0);
        tick(30);
        chk("pwrup busy", busy[1], 1);
        chk("pwrup done", done[1], 0);
        chk("pwrup no req", wreq[0], 0);
        wait_end(0, "basic");
        chk_rng("basic first req cycle", first_req[0] - rel_cyc, 101, 110);
        chk("basic done", done[0], 1);
        chk("basic busy", busy[0], 0);
        chk("basic fail", fail[0], 0);
        chk("basic writes", wr_n[0], 3);
        chk("basic idle between writes", gap_before[0][8'h41], 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("basic attempts e%0d", i), att[0][tbl[i].entry[15:8]], 1);
            chk($sformatf("basic data e%0d", i), mem[0][tbl[i].entry[15:8]], tbl[i].entry[7:0]);
            chk($sformatf("basic dev e%0d", i), devm[0][tbl[i].entry[15:8]], tbl[i].entry[23:16]);
        end
        chk("empty lut done", done[1], 1);
        chk("empty lut reqs", wr_n[1] + rd_n[1], 0);

        // entry 1 NACKs twice, then succeeds
        nack_reg[0] = 8'h41;
        nack_n[0] = 2;
        do_reset();
        wait_end(0, "retry");
        chk("retry done", done[0], 1);
        chk("retry writes", wr_n[0], 5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("retry attempts e%0d", i), att[0][tbl[i].entry[15:8]], tbl[i].wr_retry);
            chk($sformatf("retry data e%0d", i), mem[0][tbl[i].entry[15:8]], tbl[i].entry[7:0]);
        end
        chk_rng("retry gap", min_rgap[0], 50, 60);
        chk("retry req spacing", gapv[0], 0);
        chk("retry stability", stab[0], 0);

        // entry 2 always NACKs, then restart with a healthy slave
        nack_reg[0] = 8'hD6;
        nack_n[0] = 100;
        do_reset();
        wait_end(0, "exhaust");
        chk("exhaust fail", fail[0], 1);
        chk("exhaust done", done[0], 0);
        chk("exhaust busy", busy[0], 0);
        chk("exhaust fail_index", fidx[0], 2);
        chk("exhaust attempts", att[0][8'hD6], 3);
        nack_n[0] = 0;
        start_cyc = cyc;
        pulse_start(0);
        chk("restart fail cleared", fail[0], 0);
        chk("restart fail_index cleared", fidx[0], 0);
        wait_end(0, "restart");
        chk("restart done", done[0], 1);
        chk("restart first reg", first_reg[0], 8'h08);
        chk_rng("restart first req latency", first_req[0] - start_cyc, 1, 10);
        chk("restart writes", wr_n[0], 3);

        // read-back verify with one corrupted readback on reg 08
        lut_size[0] = '0;
        lut_size[1] = 3;
        bad_reg[1] = 8'h08;
        bad_n[1] = 1;
        do_reset();
        wait_end(1, "verify");
        chk("verify done", done[1], 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("verify writes e%0d", i), att[1][tbl[i].entry[15:8]], tbl[i].wr_vfy);
            chk($sformatf("verify reads e%0d", i), ratt[1][tbl[i].entry[15:8]], tbl[i].rd_vfy);
        end
        chk("verify overlap", overlap[1], 0);
        chk("verify order", seqe[1], 0);
        chk("verify req spacing", gapv[1], 0);
        chk("verify stability", stab[1], 0);

        // delay entry of 5 units between two writes
        lut_size[1] = '0;
        lut_size[0] = 3;
        lut[0][1] = 24'hFF0005;
        lut[0][2] = 24'h724110;
        do_reset();
        wait_end(0, "delay");
        chk("delay done", done[0], 1);
        chk("delay writes", wr_n[0], 2);
        chk("delay entry not written", att[0][8'h00], 0);
        chk_rng("delay idle", gap_before[0][8'h41], 50, 60);

        // asynchronous reset while a write is outstanding
        for (int i = 0; i < 3; i++) lut[0][i] = tbl[i].entry;
        hold[0] = 1'b1;
        do_reset();
        begin
            int n = 0;
            while (!wreq[0] && n < 300) begin
                tick();
                n++;
            end
        end
        chk("midwr reached", wreq[0], 1);
        #1 rst_n = 1'b0;
        #1 chk("midwr async drop", wreq[0], 0);
        chk("midwr index cleared", lut_index[0], 0);
        hold[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("midwr restart no req", wreq[0], 0);
        chk("midwr restart busy", busy[0], 1);
        chk("midwr restart done", done[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
